ex_muldiv: RTL and testbench

Iterative multiply/divide unit for the execute stage, fed directly by the ID/EX pipeline register. It performs MULT, MULTU, DIV and DIVU on 32-bit operands and owns the architectural HI/LO registers; it also services MTHI/MTLO. While an operation is in flight it raises a stall request to the hazard unit. A pipeline flush aborts the operation and leaves HI/LO intact.

---
 rtl/ex_muldiv.sv | 237 +++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and services MTHI/MTLO.
// Optional single-cycle multiplier: define MULDIV_FAST_MUL_EN.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        clr,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  cnt_r;
    logic [31:0] a_mag_r;
    logic [31:0] b_mag_r;
    logic [63:0] acc_r;
    logic        is_div_r;
    logic        res_neg_r;
    logic        rem_neg_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
    logic        busy_r;

    logic        start_md_s;
    logic        start_mt_s;
    logic        signed_op_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_step_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_step_s;
    logic [63:0] product_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;
    logic [31:0] hi_wr_s;
    logic [31:0] lo_wr_s;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Request decode; only IDLE samples start, and a flush masks it.
    always_comb begin
        start_md_s  = 1'b0;
        start_mt_s  = 1'b0;
        signed_op_s = 1'b0;
        if (start && !clr && (state_r == ST_IDLE)) begin
            start_md_s = (op[2] == 1'b0);
            start_mt_s = (op == 3'd4) || (op == 3'd5);
        end else begin
            start_md_s = 1'b0;
            start_mt_s = 1'b0;
        end
        signed_op_s = (op == 3'd0) || (op == 3'd2);
        a_abs_s     = abs32(src_a, signed_op_s);
        b_abs_s     = abs32(src_b, signed_op_s);
    end

    // One iteration of shift-add multiply and restoring divide.
    // Multiply keeps {partial product, remaining multiplier bits} in acc_r;
    // divide keeps {partial remainder, dividend/quotient bits}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
        mul_step_s  = {mul_sum_s, acc_r[31:1]};
        div_shift_s = {acc_r[63:32], acc_r[31]};
        div_diff_s  = div_shift_s - {1'b0, b_mag_r};
        if (div_diff_s[32]) begin
            div_step_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
        end else begin
            div_step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end
    end

    // Sign correction and HI/LO write data produced in FIX.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        product_s = {32'd0, a_mag_r} * {32'd0, b_mag_r};
`else
        product_s = acc_r;
`endif
        if (res_neg_r) begin
            prod_fix_s = ~product_s + 64'd1;
        end else begin
            prod_fix_s = product_s;
        end
        // Divide by zero forces an all-ones quotient regardless of signs.
        if (div_zero_r) begin
            quot_fix_s = 32'hFFFF_FFFF;
        end else begin
            quot_fix_s = neg32(acc_r[31:0], res_neg_r);
        end
        rem_fix_s = neg32(acc_r[63:32], rem_neg_r);
        if (is_div_r) begin
            hi_wr_s = rem_fix_s;
            lo_wr_s = quot_fix_s;
        end else begin
            hi_wr_s = prod_fix_s[63:32];
            lo_wr_s = prod_fix_s[31:0];
        end
    end

    // Next-state logic; a flush returns to IDLE from any state.
    always_comb begin
        state_next_s = state_r;
        if (clr) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_md_s) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next_s = op[1] ? ST_RUN : ST_FIX;
`else
                        state_next_s = ST_RUN;
`endif
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == 5'd31) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FIX:  state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register; busy is registered alongside so it mirrors state != IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 5'd0;
            a_mag_r    <= 32'd0;
            b_mag_r    <= 32'd0;
            acc_r      <= 64'd0;
            is_div_r   <= 1'b0;
            res_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (start_md_s) begin
            cnt_r      <= 5'd0;
            a_mag_r    <= a_abs_s;
            b_mag_r    <= b_abs_s;
            acc_r      <= {32'd0, (op[1] ? a_abs_s : b_abs_s)};
            is_div_r   <= op[1];
            res_neg_r  <= signed_op_s && (src_a[31] ^ src_b[31]);
            rem_neg_r  <= signed_op_s && src_a[31];
            div_zero_r <= op[1] && (src_b == 32'd0);
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r + 5'd1;
            acc_r <= is_div_r ? div_step_s : mul_step_s;
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Architectural HI/LO and the completion pulse; a flush blocks the FIX write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIX) && !clr;
            if (start_mt_s) begin
                if (op == 3'd4) begin
                    hi_r <= src_a;
                end else begin
                    lo_r <= src_a;
                end
            end else if ((state_r == ST_FIX) && !clr) begin
                hi_r <= hi_wr_s;
                lo_r <= lo_wr_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy      = busy_r;
    assign stall_req = busy_r;
    assign done      = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: random and directed ops against an arithmetic reference.
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        clr;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    ex_muldiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .clr       (clr),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] mhi      = 32'd0;
    logic [31:0] mlo      = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned up;
        longint          q;
        longint          r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin
                p = sa * sb;
                return p;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (o[1] == 1'b0) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall_eq_busy", {63'd0, stall_req}, {63'd0, busy});
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        wait_idle();
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (o <= 3'd3) begin
            r       = ref_op(o, a, b);
            e.hi    = r[63:32];
            e.lo    = r[31:0];
            e.issue = cyc;
            e.lat   = exp_lat(o);
            sb_q.push_back(e);
            mhi     = r[63:32];
            mlo     = r[31:0];
        end else if (o == 3'd4) begin
            mhi = a;
        end else if (o == 3'd5) begin
            mlo = a;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o <= 3'd3) begin
            chk("busy_after_start", {63'd0, busy}, 64'd1);
        end else begin
            chk("mt_busy", {63'd0, busy}, 64'd0);
            chk("mt_hi", {32'd0, hi}, {32'd0, mhi});
            chk("mt_lo", {32'd0, lo}, {32'd0, mlo});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        op    = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {hi, lo}, 64'd0);
        chk("rst_flags", {61'd0, busy, stall_req, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases including divide boundaries.
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'd100, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000);
        do_op(3'd3, 32'hFFFF_FFFF, 32'h8000_0001);

        // Flush mid-divide keeps the preloaded HI/LO and produces no done.
        do_op(3'd4, 32'h1234_5678, 32'd0);
        do_op(3'd5, 32'h9ABC_DEF0, 32'd0);
        wait_idle();
        start = 1'b1; op = 3'd2; src_a = 32'd10; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("busy_before_clr", {63'd0, busy}, 64'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_busy", {63'd0, busy}, 64'd0);
        chk("clr_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        // clr together with MTHI in IDLE: the write is dropped.
        start = 1'b1; op = 3'd4; src_a = 32'hFFFF_0000; clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        chk("clr_mthi", {32'd0, hi}, 64'h1234_5678);
        repeat (40) begin @(posedge clk); #1; end

        // MTLO while busy is ignored.
        do_op(3'd2, 32'd10, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 3'd5; src_a = 32'h0000_DEAD;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        chk("mtlo_ignored", {hi, lo}, 64'h0000_0001_0000_0003);

        // Reset mid-multiply clears everything at once.
        start = 1'b1; op = 3'd0; src_a = 32'd1234; src_b = 32'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {hi, lo}, 64'd0);
        chk("async_rst_flags", {61'd0, busy, stall_req, done}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(3'd1, 32'd3, 32'd5);

        // Randomised mix, including ignored opcodes 6/7 and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            if (o >= 3'd6) begin
                wait_idle();
                start = 1'b1; op = o; src_a = $urandom; src_b = $urandom;
                @(posedge clk); #1;
                start = 1'b0;
                chk("ignored_op_busy", {63'd0, busy}, 64'd0);
                chk("ignored_op_hilo", {hi, lo}, {mhi, mlo});
            end else begin
                do_op(o, rand_val(), rand_val());
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        chk("final_hilo", {hi, lo}, {mhi, mlo});
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
